// File: rtl/sha256_var_len.sv
// SHA-256 engine for variable-length messages held in word-addressed memory.
// Reads the message, generates the padding and length words itself, hashes
// one 512-bit block per pass, and writes the eight digest words back to memory.
// The hash can start from the standard IV or from a supplied midstate.
module sha256_var_len #(
    parameter  int ADDR_W    = 16,
    parameter  int MAX_WORDS = 255,
    localparam int LEN_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  num_words,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    input  logic              use_midstate,
    input  logic [255:0]      midstate_in,
    input  logic [63:0]       bit_len_base,
    output logic              busy,
    output logic              done,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    // Block counter is one bit wider than the length so the block count fits.
    localparam int B_W = LEN_W + 1;
    // Global word index {block, k}.
    localparam int G_W = B_W + 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_ROUNDS = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
        return (x >> s) | (x << (32 - s));
    endfunction

    // Control registers (reset) and their next-state values.
    logic [2:0]        state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    // Datapath registers (not reset).
    logic [LEN_W-1:0]  n_q;
    logic [ADDR_W-1:0] msg_addr_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [63:0]       len_q;
    logic              use_mid_q;
    logic [255:0]      mid_q;
    logic [B_W-1:0]    nb_q;
    logic [B_W-1:0]    blk_q;
    logic [6:0]        cnt_q;
    logic [31:0]       h_q [8];
    logic [31:0]       v_q [8];
    logic [31:0]       w_q [16];

    // Combinational helpers.
    logic [G_W-1:0]    n_ext;
    logic [B_W-1:0]    blk_inc;
    logic [G_W-1:0]    iss_g;
    logic [3:0]        cap_k;
    logic [G_W-1:0]    cap_g;
    logic              last_blk;
    logic [31:0]       cap_word;
    logic [31:0]       t1, t2, w_new;
    logic [31:0]       h_sum [8];

    assign mem_clk        = clk;
    assign busy           = busy_q;
    assign done           = done_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;

    // Word indices for the read being issued and the word being captured,
    // and the padding word that replaces memory data past the message end.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        n_ext    = G_W'(n_q);
        blk_inc  = blk_q + B_W'(1);
        iss_g    = {blk_q, cnt_q[3:0] + 4'd1};
        cap_k    = cnt_q[3:0] - 4'd1;
        cap_g    = {blk_q, cap_k};
        last_blk = (blk_inc == nb_q);
        cap_word = '0;
        if (cap_g < n_ext) begin
            cap_word = mem_read_data;
        end else if (cap_g == n_ext) begin
            cap_word = 32'h8000_0000;
        end else if (last_blk && cap_k == 4'd14) begin
            cap_word = len_q[63:32];
        end else if (last_blk && cap_k == 4'd15) begin
            cap_word = len_q[31:0];
        end
    end

    // One compression round, the next schedule word and the feed-forward sums.
    always_comb begin
        t1 = v_q[7]
           + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
           + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
           + K_TAB[cnt_q[5:0]] + w_q[0];
        t2 = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
           + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10))
              + w_q[9]
              + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3))
              + w_q[0];
        for (int i = 0; i < 8; i++) begin
            h_sum[i] = h_q[i] + v_q[i];
        end
    end

    // State sequencing and the registered memory-port values.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    busy_d  = 1'b1;
                end
            end
            S_INIT: begin
                state_d = S_LOAD;
                if (n_q != '0) mem_addr_d = msg_addr_q;
            end
            S_LOAD: begin
                if (cnt_q == 7'd16) state_d = S_ROUNDS;
                // Padding positions never touch memory; the address just holds.
                if (cnt_q < 7'd15 && iss_g < n_ext) begin
                    mem_addr_d = msg_addr_q + ADDR_W'(iss_g);
                end
            end
            S_ROUNDS: begin
                if (cnt_q == 7'd63) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (blk_inc < nb_q) begin
                    state_d = S_LOAD;
                    if ({blk_inc, 4'd0} < n_ext) begin
                        mem_addr_d = msg_addr_q + ADDR_W'({blk_inc, 4'd0});
                    end
                end else begin
                    // First digest word is the feed-forward sum formed this cycle.
                    state_d     = S_WRITE;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = out_addr_q;
                    mem_wdata_d = h_sum[0];
                end
            end
            S_WRITE: begin
                if (cnt_q == 7'd7) begin
                    state_d  = S_DONE;
                    mem_we_d = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    mem_addr_d  = out_addr_q + ADDR_W'({1'b0, cnt_q[2:0]} + 4'd1);
                    mem_wdata_d = h_q[3'(cnt_q[2:0] + 3'd1)];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers; an asynchronous reset aborts any run in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Datapath: request latch, hash state, working variables and message schedule.
    // NOTE: these registers are always written before use, so they carry no reset and can map to plain flops.
    always_ff @(posedge clk) begin
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_q        <= num_words;
                    msg_addr_q <= message_addr;
                    out_addr_q <= output_addr;
                    use_mid_q  <= use_midstate;
                    mid_q      <= midstate_in;
                    len_q      <= bit_len_base + {{(59 - LEN_W){1'b0}}, num_words, 5'b0};
                    nb_q       <= ((B_W'(num_words) + B_W'(2)) >> 4) + B_W'(1);
                end
            end
            S_INIT: begin
                for (int i = 0; i < 8; i++) begin
                    h_q[i] <= use_mid_q ? mid_q[255 - 32*i -: 32] : IV[i];
                end
                blk_q <= '0;
                cnt_q <= '0;
            end
            S_LOAD: begin
                if (cnt_q != 7'd0) w_q[cap_k] <= cap_word;
                if (cnt_q == 7'd16) begin
                    cnt_q <= '0;
                    for (int i = 0; i < 8; i++) v_q[i] <= h_q[i];
                end else begin
                    cnt_q <= cnt_q + 7'd1;
                end
            end
            S_ROUNDS: begin
                v_q[0] <= t1 + t2;
                v_q[1] <= v_q[0];
                v_q[2] <= v_q[1];
                v_q[3] <= v_q[2];
                v_q[4] <= v_q[3] + t1;
                v_q[5] <= v_q[4];
                v_q[6] <= v_q[5];
                v_q[7] <= v_q[6];
                for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                w_q[15] <= w_new;
                cnt_q   <= (cnt_q == 7'd63) ? 7'd0 : cnt_q + 7'd1;
            end
            S_UPDATE: begin
                for (int i = 0; i < 8; i++) h_q[i] <= h_sum[i];
                blk_q <= blk_inc;
                cnt_q <= '0;
            end
            S_WRITE: begin
                cnt_q <= cnt_q + 7'd1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/sha256_var_len.md
Name: sha256_var_len

Overview:
- Next-generation SHA-256 hashing engine. Hashes a message of runtime-selectable length (0..MAX_WORDS 32-bit words) held in word-addressed shared memory, and writes the 256-bit digest back to memory.
- Generates FIPS 180-4 padding on the fly: 0x80000000 marker word, zero fill, 64-bit bit-length. Any block count is supported.
- Optionally resumes from a caller-supplied midstate instead of the standard IV, for chained and precomputed-prefix hashing.

Parameters:
- ADDR_W, 16, memory word-address width
- MAX_WORDS, 255, largest accepted message length in words; LEN_W = $clog2(MAX_WORDS+1)

Ports:
- clk  in  1  clock; mem_clk is driven directly from clk
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- num_words  in  LEN_W  message length in words; sampled with start
- message_addr  in  ADDR_W  first message word; sampled with start
- output_addr  in  ADDR_W  first digest word; sampled with start
- use_midstate  in  1  1: initial hash = midstate_in; 0: standard IV; sampled with start
- midstate_in  in  256  initial hash, H0 in [255:224]; sampled with start
- bit_len_base  in  64  bits already hashed before this call; added to num_words*32 to form the length field; sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last digest write
- mem_clk  out  1  equals clk
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  registered word address
- mem_write_data  out  32  write data
- mem_read_data  in  32  read data, valid one clock after the address is presented

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_write_data=0. All other registers are don't-care. Reset mid-operation aborts immediately; no further memory writes occur.
- Block count: nb = (num_words+2)/16 + 1 (integer division). Examples: 0→1, 13→1, 14→2, 20→2, 29→2, 30→3.
- Global word index g = 16*blk + k, with k = 0..15 within the block.
  - g < n: memory word at message_addr+g.
  - g == n: 0x80000000.
  - k = 14 of the last block: length[63:32].
  - k = 15 of the last block: length[31:0].
  - Otherwise: 0.
  - length = bit_len_base + n*32, computed at 64-bit width; wraps mod 2^64.
- Reads are issued only for g < n. Padding words must never cause a memory access. mem_we=0 throughout READ.
- States: IDLE → INIT → LOAD → ROUNDS → UPDATE → (LOAD | WRITE) → DONE → IDLE.
- IDLE: when start=1, latch all inputs; busy=1 next cycle. start while busy is ignored.
- INIT (1 cycle): H = use_midstate ? midstate_in : IV; blk=0.
- LOAD (17 cycles/block): issue addresses k=0..15 back to back. Capture each word one cycle later into w[k]. Padding words are muxed in place of the memory data.
- ROUNDS (64 cycles): copy H into a..h on the first cycle.
  - One compression round per cycle, t = 0..63.
  - Rounds t ≥ 16 use the 16-word sliding schedule: w_new = σ1(w[t-2]) + w[t-7] + σ0(w[t-15]) + w[t-16].
  - All arithmetic mod 2^32.
- UPDATE (1 cycle): H[i] += working var[i]; blk++. If blk < nb go to LOAD, else go to WRITE.
- WRITE (8 cycles): mem_we=1; mem_addr = output_addr+0..7; data = H0..H7 in order; mem_we=0 on exit.
- DONE (1 cycle): done=1, busy=0; then IDLE.
- Fixed latency: start-to-done = 1 + 1 + nb*(17+64+1) + 8 + 1 cycles; nb=2 gives 175.
- Address arithmetic wraps mod 2^ADDR_W.
- num_words > MAX_WORDS cannot be represented by the port width; any value on the port is legal.

Test Plan:
- n=0, use_midstate=0, base=0 → zero reads; digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855 at output_addr..+7; done 93 cycles after start.
- n=1, word 0x61626364 ("abcd") → exactly 1 read; digest 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589.
- n=13, 14, 20, 30 with random data → nb = 1, 2, 2, 3; digests match the software model; read count equals n; no read address ≥ message_addr+n.
- Midstate: hash the first 16 words of a 20-word message standalone, then rerun the last 4 words with use_midstate=1, midstate_in = the standalone H (pre-padding state taken from the model), base=512 → digest equals the n=20 single-call digest.
- start pulsed again while busy; then reset_n asserted mid-ROUNDS → second start ignored; after reset busy=0, done=0, mem_we=0 and no writes; a fresh n=0 run is correct.
- message_addr = 2^ADDR_W-2, n=4 → read addresses wrap 0xFFFE, 0xFFFF, 0x0000, 0x0001; digest matches the model.
